// File: rtl/mont_exp_ctrl.sv
// Square-and-multiply sequencer for a Montgomery multiplier (montgomery_wrap).
// Converts the base into the Montgomery domain, scans the exponent MSB first
// (square on every bit, multiply on every set bit), then converts the
// accumulator back to the normal domain and presents base^exp mod m.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start_p             one-cycle start, accepted only in IDLE
//   base, exp, exp_size operand, exponent and number of exponent bits scanned
//   m, m_size, r_red    modulus, its bit length and the multiplier constant
//   r2                  R^2 mod m used for conversion into the Montgomery domain
//   mm_*                multiplier request (enable, operands, latched constants)
//   mm_y, mm_done_p     multiplier result and completion pulse
//   busy, done_p        run in progress / one-cycle completion
//   err, result         even-modulus flag and final result, held until next start
//
// state  | meaning
// IDLE   | waiting for start_p
// ISSUE  | mm_enable_p pulse for the current op
// WAIT   | waiting for mm_done_p, then capture mm_y and pick next op
// DONE   | done_p pulse, result valid
module mont_exp_ctrl #(
    parameter int NBITS = 256,
    parameter int SW    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic [NBITS-1:0] base,
    input  logic [NBITS-1:0] exp,
    input  logic [SW-1:0]    exp_size,
    input  logic [NBITS-1:0] m,
    input  logic [SW-1:0]    m_size,
    input  logic [NBITS-1:0] r_red,
    input  logic [NBITS-1:0] r2,
    output logic             mm_enable_p,
    output logic [NBITS-1:0] mm_a,
    output logic [NBITS-1:0] mm_b,
    output logic [NBITS-1:0] mm_m,
    output logic [SW-1:0]    mm_m_size,
    output logic [NBITS-1:0] mm_r_red,
    input  logic [NBITS-1:0] mm_y,
    input  logic             mm_done_p,
    output logic             busy,
    output logic             done_p,
    output logic             err,
    output logic [NBITS-1:0] result
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [NBITS-1:0] ONE = NBITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_CONV_B,
        OP_CONV_1,
        OP_SQR,
        OP_MUL,
        OP_FINAL
    } op_t;

    state_t state_q, state_d;
    op_t    op_q, op_d;

    logic [NBITS-1:0] base_q;
    logic [NBITS-1:0] exp_q;
    logic [NBITS-1:0] r2_q;
    logic [NBITS-1:0] bm_q;
    logic [NBITS-1:0] acc_q;
    // One extra bit: decrementing past 0 sets the MSB, which marks "no bits left".
    logic [SW:0]      bit_idx_q;
    logic [SW-1:0]    exp_eff;
    logic             accept;
    logic             capture;
    logic             dec_bit;
    logic             last_bit;

    assign exp_eff  = (exp_size > SW'(NBITS)) ? SW'(NBITS) : exp_size;
    assign last_bit = (bit_idx_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_CONV_B;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        accept      = 1'b0;
        capture     = 1'b0;
        dec_bit     = 1'b0;
        mm_enable_p = 1'b0;
        busy        = 1'b0;
        done_p      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    accept  = 1'b1;
                    op_d    = OP_CONV_B;
                    // An even modulus has no R^-1, so skip straight to DONE.
                    state_d = m[0] ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                mm_enable_p = 1'b1;
                busy        = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mm_done_p) begin
                    capture = 1'b1;
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_CONV_B: op_d = OP_CONV_1;
                        OP_CONV_1: op_d = bit_idx_q[SW] ? OP_FINAL : OP_SQR;
                        OP_SQR: begin
                            if (exp_q[bit_idx_q[IW-1:0]]) begin
                                op_d = OP_MUL;
                            end else begin
                                dec_bit = 1'b1;
                                op_d    = last_bit ? OP_FINAL : OP_SQR;
                            end
                        end
                        OP_MUL: begin
                            dec_bit = 1'b1;
                            op_d    = last_bit ? OP_FINAL : OP_SQR;
                        end
                        OP_FINAL: state_d = S_DONE;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_DONE: begin
                done_p  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operands come straight from registers that only change on the capture
    // edge, so they stay stable from ISSUE through the mm_done_p cycle.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        if (busy) begin
            case (op_q)
                OP_CONV_B: begin mm_a = base_q; mm_b = r2_q;  end
                OP_CONV_1: begin mm_a = ONE;    mm_b = r2_q;  end
                OP_SQR:    begin mm_a = acc_q;  mm_b = acc_q; end
                OP_MUL:    begin mm_a = acc_q;  mm_b = bm_q;  end
                OP_FINAL:  begin mm_a = acc_q;  mm_b = ONE;   end
                default:   begin mm_a = '0;     mm_b = '0;    end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            exp_q     <= '0;
            r2_q      <= '0;
            bm_q      <= '0;
            acc_q     <= '0;
            bit_idx_q <= '0;
            mm_m      <= '0;
            mm_m_size <= '0;
            mm_r_red  <= '0;
            err       <= 1'b0;
            result    <= '0;
        end else begin
            if (accept) begin
                base_q    <= base;
                exp_q     <= exp;
                r2_q      <= r2;
                bit_idx_q <= {1'b0, exp_eff} - (SW+1)'(1);
                mm_m      <= m;
                mm_m_size <= m_size;
                mm_r_red  <= r_red;
                err       <= ~m[0];
                result    <= '0;
            end
            if (capture) begin
                case (op_q)
                    OP_CONV_B: bm_q   <= mm_y;
                    OP_FINAL:  result <= mm_y;
                    default:   acc_q  <= mm_y;
                endcase
            end
            if (dec_bit) begin
                bit_idx_q <= bit_idx_q - (SW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
module tb_mont_exp_ctrl;

    localparam int NBITS = 256;
    localparam int SW    = 11;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_p = 1'b0;
    logic [NBITS-1:0] base_in = '0;
    logic [NBITS-1:0] exp_in = '0;
    logic [SW-1:0]    exp_size_in = '0;
    logic [NBITS-1:0] m_in = '0;
    logic [SW-1:0]    m_size_in = '0;
    logic [NBITS-1:0] r_red_in = '0;
    logic [NBITS-1:0] r2_in = '0;
    logic             mm_enable_p;
    logic [NBITS-1:0] mm_a, mm_b, mm_m, mm_r_red;
    logic [SW-1:0]    mm_m_size;
    logic [NBITS-1:0] mm_y = '0;
    logic             mm_done_p = 1'b0;
    logic             busy, done_p, err;
    logic [NBITS-1:0] result;

    mont_exp_ctrl #(.NBITS(NBITS), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start_p(start_p),
        .base(base_in), .exp(exp_in), .exp_size(exp_size_in),
        .m(m_in), .m_size(m_size_in), .r_red(r_red_in), .r2(r2_in),
        .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b),
        .mm_m(mm_m), .mm_m_size(mm_m_size), .mm_r_red(mm_r_red),
        .mm_y(mm_y), .mm_done_p(mm_done_p),
        .busy(busy), .done_p(done_p), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // a*b*2^-n mod m by halving, valid for odd m.
    function automatic longint unsigned mm_f(longint unsigned a, longint unsigned b,
                                             longint unsigned mv, int n);
        longint unsigned t;
        if (mv == 0) return 0;
        t = a * b;
        for (int k = 0; k < n; k++) begin
            if (t[0]) t = t + mv;
            t = t >> 1;
        end
        return t % mv;
    endfunction

    function automatic int clamp_es(int es);
        return (es > NBITS) ? NBITS : es;
    endfunction

    // Right-to-left binary exponentiation on plain integers.
    function automatic longint unsigned ref_modexp(longint unsigned b, logic [NBITS-1:0] e,
                                                   int es, longint unsigned mv);
        longint unsigned r, p;
        int n;
        n = clamp_es(es);
        r = 1 % mv;
        p = b % mv;
        for (int k = 0; k < n; k++) begin
            if (e[k]) r = (r * p) % mv;
            p = (p * p) % mv;
        end
        return r;
    endfunction

    function automatic int ref_ops(logic [NBITS-1:0] e, int es);
        int n, c;
        n = clamp_es(es);
        c = 3 + n;
        for (int k = 0; k < n; k++) c += int'(e[k]);
        return c;
    endfunction

    function automatic int bitlen(longint unsigned v);
        int n;
        n = 0;
        while (v != 0) begin n++; v = v >> 1; end
        return n;
    endfunction

    // ---------------- multiplier model (fixed latency) ----------------
    int               enable_count = 0;
    bit               pend = 0;
    bit               aborted = 0;
    bit               stable_ok = 0;
    bit               inject = 0;
    int               cnt = 0;
    logic [NBITS-1:0] ca, cb, cm, crr;
    logic [SW-1:0]    cms;

    always @(negedge clk) begin
        mm_done_p = 1'b0;
        if (pend) begin
            if (rst) aborted = 1;
            if (!aborted)
                stable_ok &= (mm_a == ca) && (mm_b == cb) && (mm_m == cm) &&
                             (mm_m_size == cms) && (mm_r_red == crr);
            cnt--;
            if (cnt == 0) begin
                if (!aborted) check("mm_operands_stable", NBITS'(stable_ok), NBITS'(1));
                mm_y      = NBITS'(mm_f(ca[63:0], cb[63:0], cm[63:0], int'(cms)));
                mm_done_p = 1'b1;
                pend      = 0;
            end
        end else if (inject) begin
            mm_y      = {8{$urandom}};
            mm_done_p = 1'b1;
            inject    = 0;
        end
        if (mm_enable_p && !rst) begin
            check("mm_enable_overlap", NBITS'(pend), '0);
            enable_count++;
            pend      = 1;
            aborted   = 0;
            stable_ok = 1;
            cnt       = LAT;
            ca = mm_a; cb = mm_b; cm = mm_m; cms = mm_m_size; crr = mm_r_red;
        end
    end

    // ---------------- compare process ----------------
    bit               run_active = 0;
    logic [NBITS-1:0] exp_result = '0, held_result = '0;
    bit               exp_err = 0, held_err = 0;
    int               exp_ops = 0, ops_base = 0;
    logic [NBITS-1:0] exp_m = '0, exp_rred = '0;
    logic [SW-1:0]    exp_msize = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (done_p) begin
                check("done_expected", NBITS'(run_active), NBITS'(1));
                check("result", result, exp_result);
                check("err", NBITS'(err), NBITS'(exp_err));
                check("op_count", NBITS'(enable_count - ops_base), NBITS'(exp_ops));
                check("busy_at_done", NBITS'(busy), '0);
                run_active  = 0;
                held_result = exp_result;
                held_err    = exp_err;
            end else if (busy) begin
                check("busy_expected", NBITS'(run_active), NBITS'(1));
                check("mm_m", mm_m, exp_m);
                check("mm_m_size", NBITS'(mm_m_size), NBITS'(exp_msize));
                check("mm_r_red", mm_r_red, exp_rred);
            end else if (!run_active) begin
                check("idle_busy", NBITS'(busy), '0);
                check("idle_enable", NBITS'(mm_enable_p), '0);
                check("held_result", result, held_result);
                check("held_err", NBITS'(err), NBITS'(held_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run_active = 0;
        held_result = '0;
        held_err = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_inputs(input logic [NBITS-1:0] b, e, input logic [SW-1:0] es,
                                input logic [NBITS-1:0] mv, input logic [SW-1:0] ms,
                                input logic [NBITS-1:0] rr, r2v);
        base_in = b; exp_in = e; exp_size_in = es; m_in = mv;
        m_size_in = ms; r_red_in = rr; r2_in = r2v;
    endtask

    task automatic randomize_inputs();
        drive_inputs({8{$urandom}}, {8{$urandom}}, SW'($urandom), {8{$urandom}},
                     SW'($urandom), {8{$urandom}}, {8{$urandom}});
    endtask

    // mode 0: plain, 1: perturb inputs + re-pulse start while busy, 2: start in DONE cycle
    task automatic run_exp(input logic [NBITS-1:0] b, e, input logic [SW-1:0] es,
                           input logic [NBITS-1:0] mv, input logic [SW-1:0] ms,
                           input logic [NBITS-1:0] rr, r2v, exp_res,
                           input bit exp_e, input int ops, input int mode);
        int cyc, limit;
        exp_result = exp_res; exp_err = exp_e; exp_ops = ops;
        exp_m = mv; exp_msize = ms; exp_rred = rr;
        ops_base = enable_count;
        run_active = 1;
        drive_inputs(b, e, es, mv, ms, rr, r2v);
        start_p = 1'b1;
        tick();
        start_p = 1'b0;
        if (!mv[0]) check("even_done_next_cycle", NBITS'(done_p), NBITS'(1));
        if (mode == 1) randomize_inputs();
        limit = 10 * ops + 40;
        cyc = 0;
        while (!done_p && cyc < limit) begin
            tick();
            cyc++;
            start_p = (mode == 1 && cyc == 8) ? 1'b1 : 1'b0;
        end
        start_p = 1'b0;
        if (!done_p) begin
            check("done_timeout", NBITS'(done_p), NBITS'(1));
            do_reset();
            return;
        end
        if (mode == 2) begin
            base_in = 4; exp_in = 3; exp_size_in = 2; m_in = 13; m_size_in = 4; r2_in = 9;
            start_p = 1'b1;
        end
        tick();
        start_p = 1'b0;
        if (mode == 2) begin
            check("start_in_done_ignored", NBITS'(busy), '0);
            tick();
            check("start_in_done_no_issue", NBITS'(mm_enable_p | busy), '0);
        end
    endtask

    task automatic run_auto(input longint unsigned mv, input int es, input logic [NBITS-1:0] e,
                            input int mode);
        int ms;
        longint unsigned rmod, r2v, b;
        logic [NBITS-1:0] rr;
        rr = {8{$urandom}};
        ms = bitlen(mv);
        if (mv[0]) begin
            rmod = (64'd1 << ms) % mv;
            r2v  = (rmod * rmod) % mv;
            b    = {32'd0, $urandom} % mv;
            run_exp(NBITS'(b), e, SW'(es), NBITS'(mv), SW'(ms), rr, NBITS'(r2v),
                    NBITS'(ref_modexp(b, e, es, mv)), 1'b0, ref_ops(e, es), mode);
        end else begin
            run_exp(NBITS'(5), e, SW'(es), NBITS'(mv), SW'(ms), rr, NBITS'(7),
                    '0, 1'b1, 0, mode);
        end
    endtask

    initial begin
        logic [NBITS-1:0] e;
        longint unsigned mv;
        int cyc;

        // model pins
        check("pin_mm_f", NBITS'(mm_f(1, 9, 13, 4)), NBITS'(3));
        check("pin_modexp_a", NBITS'(ref_modexp(4, NBITS'(13), 4, 13)), NBITS'(4));
        check("pin_modexp_b", NBITS'(ref_modexp(2, NBITS'(10), 4, 13)), NBITS'(10));
        check("pin_ops", NBITS'(ref_ops(NBITS'(13), 4)), NBITS'(10));

        // reset values
        rst = 1'b1;
        tick(); tick();
        check("rst_enable", NBITS'(mm_enable_p), '0);
        check("rst_busy", NBITS'(busy), '0);
        check("rst_done", NBITS'(done_p), '0);
        check("rst_err", NBITS'(err), '0);
        check("rst_result", result, '0);
        check("rst_mm_a_b", mm_a | mm_b, '0);
        check("rst_mm_consts", mm_m | mm_r_red | NBITS'(mm_m_size), '0);
        rst = 1'b0;
        tick(); tick();

        // nominal, zero exponent, exp_size 0, even modulus
        run_exp(4, 13, 4, 13, 4, 'h5A, 9, 4, 1'b0, 10, 0);
        run_exp(4, 0, 4, 13, 4, 'h5A, 9, 1, 1'b0, 7, 0);
        run_exp(4, 0, 0, 13, 4, 'h5A, 9, 1, 1'b0, 3, 0);
        run_exp(4, 13, 4, 12, 4, 'h33, 9, 0, 1'b1, 0, 0);
        tick();

        // re-pulsed start and changed inputs while busy
        run_exp(4, 13, 4, 13, 4, 'h77, 9, 4, 1'b0, 10, 1);
        tick();

        // mm_done_p in IDLE
        inject = 1;
        tick(); tick(); tick();
        check("idle_inject_result", result, NBITS'(4));
        check("idle_inject_busy", NBITS'(busy), '0);

        // reset during the 4th WAIT
        exp_m = 13; exp_msize = 4; exp_rred = 'h11;
        ops_base = enable_count;
        run_active = 1;
        drive_inputs(4, 13, 4, 13, 4, 'h11, 9);
        start_p = 1'b1;
        tick();
        start_p = 1'b0;
        cyc = 0;
        while ((enable_count - ops_base) < 4 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("reached_4th_wait", NBITS'(enable_count - ops_base), NBITS'(4));
        do_reset();
        check("rst_mid_busy", NBITS'(busy), '0);
        check("rst_mid_enable", NBITS'(mm_enable_p), '0);
        check("rst_mid_done", NBITS'(done_p), '0);
        repeat (10) tick();
        run_exp(2, 10, 4, 13, 4, 'h22, 9, 10, 1'b0, 9, 0);

        // back-to-back, including a start during DONE
        run_exp(4, 13, 4, 13, 4, 'h5A, 9, 4, 1'b0, 10, 2);
        run_exp(2, 10, 4, 13, 4, 'h5A, 9, 10, 1'b0, 9, 0);
        run_exp(4, 13, 4, 13, 4, 'h5A, 9, 4, 1'b0, 10, 0);

        // exp_size beyond NBITS is clamped
        e = {8{$urandom}};
        run_auto(64'd1000003, 300, e, 0);

        // randomized runs
        for (int k = 0; k < 25; k++) begin
            e  = {8{$urandom}};
            mv = longint'($urandom_range(3, (1 << 20) - 1)) | 64'd1;
            if ($urandom_range(0, 7) == 0) mv = mv & ~64'd1;
            run_auto(mv, $urandom_range(0, 16), e, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
        end

        repeat (12) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
